// File: rtl/viterbi_soft_decoder.sv
// viterbi_soft_decoder
// Frame-based soft-decision Viterbi decoder for a rate-1/2 convolutional code.
// Symbols are accepted one at a time. Each accepted symbol runs an
// add-compare-select pass over all trellis states, one state per cycle, and
// stores one survivor decision per state. At frame end the decoder picks a
// start state, traces back through the survivor memory, and streams the
// decoded bits out oldest first.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   sym_valid  a soft symbol is presented (sampled only while in RECV)
//   sym_ready  decoder can accept a symbol
//   sym_c0     soft value of code bit 0 (G0): 0 = strong 0, 2^SW-1 = strong 1
//   sym_c1     soft value of code bit 1 (G1)
//   sym_last   final symbol of the frame
//   term_mode  1 = tail-terminated frame; sampled with the first symbol
//   bit_valid  a decoded bit is presented
//   bit_ready  consumer accepts the bit
//   bit_out    decoded bit
//   bit_last   final decoded bit of the frame
//   busy       high during ACS, BEST and TRACE
//   trunc      sticky: frame was cut at MAX_FRAME symbols
module viterbi_soft_decoder #(
  parameter int             K         = 5,
  parameter logic [K-1:0]   G0        = 5'b10011,
  parameter logic [K-1:0]   G1        = 5'b11101,
  parameter int             SW        = 3,
  parameter int             PM_WIDTH  = 10,
  parameter int             MAX_FRAME = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sym_valid,
  output logic          sym_ready,
  input  logic [SW-1:0] sym_c0,
  input  logic [SW-1:0] sym_c1,
  input  logic          sym_last,
  input  logic          term_mode,
  output logic          bit_valid,
  input  logic          bit_ready,
  output logic          bit_out,
  output logic          bit_last,
  output logic          busy,
  output logic          trunc
);

  localparam int M  = K - 1;
  localparam int NS = 1 << M;
  localparam int AW = $clog2(MAX_FRAME);

  localparam logic [SW-1:0]       SMAX     = {SW{1'b1}};
  localparam logic [PM_WIDTH-1:0] PM_MAX   = {PM_WIDTH{1'b1}};
  localparam logic [PM_WIDTH-1:0] PM_INIT  = {2'b01, {(PM_WIDTH-2){1'b0}}};
  localparam logic [M-1:0]        IDX_LAST = {M{1'b1}};
  localparam logic [AW:0]         CNT_LAST = (AW+1)'(MAX_FRAME - 1);

  localparam logic [2:0] S_RECV  = 3'd0;
  localparam logic [2:0] S_ACS   = 3'd1;
  localparam logic [2:0] S_BEST  = 3'd2;
  localparam logic [2:0] S_TRACE = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]          state_reg;
  logic                started_reg;   // holds sym_ready low until the first edge after reset
  logic [PM_WIDTH-1:0] pm_reg [2][NS]; // ping-pong metric banks
  logic                bank_reg;      // bank holding the most recent metrics
  logic [PM_WIDTH-1:0] norm_reg;
  logic [PM_WIDTH-1:0] min_reg;
  logic [M-1:0]        idx_reg;       // ACS state index, reused as BEST scan index
  logic [AW:0]         frame_cnt_reg;
  logic [AW-1:0]       cur_t_reg;     // time index of the symbol being processed
  logic [SW-1:0]       c0_reg, c1_reg;
  logic                last_reg, term_reg, trunc_reg;
  logic [NS-1:0]       dec_reg;
  logic [PM_WIDTH-1:0] best_pm_reg;
  logic [M-1:0]        best_st_reg;
  logic [M-1:0]        tb_st_reg;
  logic [AW-1:0]       tb_t_reg;
  logic [AW-1:0]       out_idx_reg;
  logic [MAX_FRAME-1:0] bits_reg;

  logic [NS-1:0]       surv_mem [MAX_FRAME];
  logic [NS-1:0]       surv_rd_reg;
  logic [AW-1:0]       surv_rd_addr;

  // Expected code pair for the branch from predecessor p with input u, scored
  // against the soft symbol.
  function automatic logic [SW:0] bm_f(input logic [M-1:0] p, input logic u,
                                       input logic [SW-1:0] x0, input logic [SW-1:0] x1);
    logic [K-1:0]  r;
    logic [SW-1:0] d0, d1;
    r  = {p, u};
    d0 = (^(r & G0)) ? (SMAX - x0) : x0;
    d1 = (^(r & G1)) ? (SMAX - x1) : x1;
    return {1'b0, d0} + {1'b0, d1};
  endfunction

  function automatic logic [PM_WIDTH-1:0] acs_cand(input logic [PM_WIDTH-1:0] pm,
                                                   input logic [PM_WIDTH-1:0] nrm,
                                                   input logic [SW:0] bm);
    logic [PM_WIDTH:0] sum;
    sum = {1'b0, pm - nrm} + {{(PM_WIDTH-SW){1'b0}}, bm};
    return sum[PM_WIDTH] ? PM_MAX : sum[PM_WIDTH-1:0];
  endfunction

  // ACS datapath for state idx_reg
  logic [M-1:0]        p0, p1;
  logic [PM_WIDTH-1:0] cand0, cand1, new_pm, min_next;
  logic                sel1;
  logic [NS-1:0]       dec_word;

  assign p0    = {1'b0, idx_reg[M-1:1]};
  assign p1    = {1'b1, idx_reg[M-1:1]};
  assign cand0 = acs_cand(pm_reg[bank_reg][p0], norm_reg, bm_f(p0, idx_reg[0], c0_reg, c1_reg));
  assign cand1 = acs_cand(pm_reg[bank_reg][p1], norm_reg, bm_f(p1, idx_reg[0], c0_reg, c1_reg));
  assign sel1  = cand1 < cand0;   // ties resolve to pred0
  assign new_pm   = sel1 ? cand1 : cand0;
  assign min_next = (idx_reg == '0 || new_pm < min_reg) ? new_pm : min_reg;

  always_comb begin
    dec_word          = dec_reg;
    dec_word[idx_reg] = sel1;
  end

  // BEST scan: strict less-than keeps the lowest index among equal minima
  logic [PM_WIDTH-1:0] scan_pm;
  logic                best_upd;
  logic [M-1:0]        best_st_next;

  assign scan_pm      = pm_reg[bank_reg][idx_reg];
  assign best_upd     = (idx_reg == '0) || (scan_pm < best_pm_reg);
  assign best_st_next = best_upd ? idx_reg : best_st_reg;

  // The survivor word for the next traceback step is fetched one cycle ahead,
  // so the last BEST cycle already reads the final time step.
  assign surv_rd_addr = (state_reg == S_TRACE) ? tb_t_reg - 1'b1 : cur_t_reg;

  logic sym_acc, bit_acc, out_is_last;
  assign sym_ready   = (state_reg == S_RECV) && started_reg;
  assign sym_acc     = sym_ready && sym_valid;
  assign out_is_last = ({1'b0, out_idx_reg} == frame_cnt_reg - 1'b1);
  assign bit_valid   = (state_reg == S_OUT);
  assign bit_acc     = bit_valid && bit_ready;
  assign bit_out     = bit_valid && bits_reg[out_idx_reg];
  assign bit_last    = bit_valid && out_is_last;
  assign busy        = (state_reg == S_ACS) || (state_reg == S_BEST) || (state_reg == S_TRACE);
  assign trunc       = trunc_reg;

  always_ff @(posedge clk) begin
    if (state_reg == S_ACS && idx_reg == IDX_LAST)
      surv_mem[cur_t_reg] <= dec_word;
    surv_rd_reg <= surv_mem[surv_rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_RECV;
      started_reg   <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < NS; s++)
          pm_reg[b][s] <= (s == 0) ? '0 : PM_INIT;
      bank_reg      <= 1'b0;
      norm_reg      <= '0;
      min_reg       <= '0;
      idx_reg       <= '0;
      frame_cnt_reg <= '0;
      cur_t_reg     <= '0;
      c0_reg        <= '0;
      c1_reg        <= '0;
      last_reg      <= 1'b0;
      term_reg      <= 1'b0;
      trunc_reg     <= 1'b0;
      dec_reg       <= '0;
      best_pm_reg   <= '0;
      best_st_reg   <= '0;
      tb_st_reg     <= '0;
      tb_t_reg      <= '0;
      out_idx_reg   <= '0;
      bits_reg      <= '0;
    end else begin
      started_reg <= 1'b1;
      case (state_reg)
        S_RECV: begin
          if (sym_acc) begin
            c0_reg        <= sym_c0;
            c1_reg        <= sym_c1;
            last_reg      <= sym_last || (frame_cnt_reg == CNT_LAST);
            cur_t_reg     <= frame_cnt_reg[AW-1:0];
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
            if (frame_cnt_reg == '0) begin
              term_reg  <= term_mode;
              trunc_reg <= 1'b0;
            end
            if (frame_cnt_reg == CNT_LAST && !sym_last)
              trunc_reg <= 1'b1;
            idx_reg   <= '0;
            state_reg <= S_ACS;
          end
        end
        S_ACS: begin
          pm_reg[~bank_reg][idx_reg] <= new_pm;
          min_reg <= min_next;
          dec_reg <= dec_word;
          if (idx_reg == IDX_LAST) begin
            bank_reg  <= ~bank_reg;
            norm_reg  <= min_next;
            idx_reg   <= '0;
            state_reg <= last_reg ? S_BEST : S_RECV;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        S_BEST: begin
          best_st_reg <= best_st_next;
          if (best_upd)
            best_pm_reg <= scan_pm;
          if (term_reg || idx_reg == IDX_LAST) begin
            tb_st_reg <= term_reg ? '0 : best_st_next;
            tb_t_reg  <= cur_t_reg;
            idx_reg   <= '0;
            state_reg <= S_TRACE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        S_TRACE: begin
          bits_reg[tb_t_reg] <= tb_st_reg[0];
          tb_st_reg <= {surv_rd_reg[tb_st_reg], tb_st_reg[M-1:1]};
          if (tb_t_reg == '0) begin
            out_idx_reg <= '0;
            state_reg   <= S_OUT;
          end else begin
            tb_t_reg <= tb_t_reg - 1'b1;
          end
        end
        S_OUT: begin
          if (bit_acc) begin
            if (out_is_last) begin
              for (int b = 0; b < 2; b++)
                for (int s = 0; s < NS; s++)
                  pm_reg[b][s] <= (s == 0) ? '0 : PM_INIT;
              bank_reg      <= 1'b0;
              norm_reg      <= '0;
              frame_cnt_reg <= '0;
              state_reg     <= S_RECV;
            end else begin
              out_idx_reg <= out_idx_reg + 1'b1;
            end
          end
        end
        default: state_reg <= S_RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_soft_decoder.sv
// tb_viterbi_soft_decoder
// Drives frames of soft symbols into two decoder instances (default metric
// width and a narrow 7-bit metric width) in lockstep and checks the decoded
// bits against a whole-frame Viterbi reference model and, where the channel
// allows it, against the original data.
module tb_viterbi_soft_decoder;

  localparam int K    = 5;
  localparam int M    = K - 1;
  localparam int NS   = 1 << M;
  localparam int SMAX = 7;
  localparam int MAXF = 64;
  localparam int G0I  = 'b10011;
  localparam int G1I  = 'b11101;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sym_valid = 1'b0;
  logic [2:0] sym_c0 = '0, sym_c1 = '0;
  logic       sym_last = 1'b0, term_mode = 1'b0;
  logic       bit_ready = 1'b0;
  logic       sym_ready, bit_valid, bit_out, bit_last, busy, trunc;
  logic       sym_ready_7, bit_valid_7, bit_out_7, bit_last_7, busy_7, trunc_7;

  always #5 clk = ~clk;

  viterbi_soft_decoder dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_c0(sym_c0), .sym_c1(sym_c1), .sym_last(sym_last), .term_mode(term_mode),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_out(bit_out),
    .bit_last(bit_last), .busy(busy), .trunc(trunc)
  );

  viterbi_soft_decoder #(.PM_WIDTH(7)) dut7 (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_ready(sym_ready_7),
    .sym_c0(sym_c0), .sym_c1(sym_c1), .sym_last(sym_last), .term_mode(term_mode),
    .bit_valid(bit_valid_7), .bit_ready(bit_ready), .bit_out(bit_out_7),
    .bit_last(bit_last_7), .busy(busy_7), .trunc(trunc_7)
  );

  int total = 0;
  int bad   = 0;
  int s0 [MAXF];
  int s1 [MAXF];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Rate-1/2 encoder starting in state 0, hard symbols 0 / SMAX.
  task automatic encode(input logic [63:0] data, input int n);
    int st, r;
    st = 0;
    for (int t = 0; t < n; t++) begin
      r = (st << 1) | int'(data[t]);
      s0[t] = ($countones(r & G0I) % 2) ? SMAX : 0;
      s1[t] = ($countones(r & G1I) % 2) ? SMAX : 0;
      st = ((st << 1) | int'(data[t])) & (NS - 1);
    end
  endtask

  // Whole-frame Viterbi on integers for a given metric width.
  task automatic model_run(input int n, input bit term, input int pmw, output logic [63:0] ob);
    int pm [NS];
    int npm [NS];
    bit dec [MAXF][NS];
    int c [2];
    int norm, mx, mn, st, p, r, bm, e0, e1;
    mx = (1 << pmw) - 1;
    for (int s = 0; s < NS; s++) pm[s] = (s == 0) ? 0 : (1 << (pmw - 2));
    norm = 0;
    ob = '0;
    for (int t = 0; t < n; t++) begin
      mn = mx + 1;
      for (int s = 0; s < NS; s++) begin
        for (int b = 0; b < 2; b++) begin
          p  = (b << (M - 1)) | (s >> 1);
          r  = (p << 1) | (s & 1);
          e0 = $countones(r & G0I) % 2;
          e1 = $countones(r & G1I) % 2;
          bm = (e0 != 0 ? SMAX - s0[t] : s0[t]) + (e1 != 0 ? SMAX - s1[t] : s1[t]);
          c[b] = pm[p] - norm + bm;
          if (c[b] > mx) c[b] = mx;
        end
        dec[t][s] = (c[1] < c[0]);
        npm[s] = dec[t][s] ? c[1] : c[0];
        if (npm[s] < mn) mn = npm[s];
      end
      pm = npm;
      norm = mn;
    end
    st = 0;
    if (!term)
      for (int s = 1; s < NS; s++) if (pm[s] < pm[st]) st = s;
    for (int t = n - 1; t >= 0; t--) begin
      ob[t] = st[0];
      st = (int'(dec[t][st]) << (M - 1)) | (st >> 1);
    end
  endtask

  task automatic run_frame(input string name, input int n, input bit term, input bit use_last,
                           input bit bp, input bit check_data, input logic [63:0] data,
                           input bit exp_trunc);
    logic [63:0] exp10, exp7, got, got7, mask;
    int   cnt, cnt7, lastpos, lowcnt, wd;
    bit   hold_pend;
    logic hold_val;
    model_run(n, term, 10, exp10);
    model_run(n, term, 7, exp7);
    mask = (n >= 64) ? '1 : ((64'(1) << n) - 64'(1));
    got = '0; got7 = '0; cnt = 0; cnt7 = 0; lastpos = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sym_valid = 1'b1;
      sym_c0    = 3'(s0[i]);
      sym_c1    = 3'(s1[i]);
      sym_last  = use_last && (i == n - 1);
      term_mode = term;
      wd = 0;
      while (!sym_ready && wd < 200) begin @(negedge clk); wd++; end
      if (!sym_ready) begin
        chk({name, " sym_ready_timeout"}, 0, 1);
        sym_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      sym_valid = 1'b0;
      sym_last  = 1'b0;
      if (i < n - 1) begin
        lowcnt = 0;
        while (!sym_ready && lowcnt < 100) begin lowcnt++; @(negedge clk); end
        chk({name, " ready_low_cycles"}, lowcnt, NS);
      end else begin
        chk({name, " busy_after_last"}, {sym_ready, busy}, 2'b01);
      end
    end
    wd = 0;
    hold_pend = 0;
    hold_val = 1'b0;
    while ((cnt < n || cnt7 < n) && wd < 3000) begin
      @(negedge clk);
      wd++;
      if (hold_pend) begin
        chk({name, " hold"}, {bit_valid, bit_out}, {1'b1, hold_val});
        hold_pend = 0;
      end
      bit_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bit_valid && bit_ready && cnt < 64) begin
        got[cnt] = bit_out;
        if (bit_last) lastpos = cnt;
        cnt++;
      end else if (bit_valid && !bit_ready) begin
        hold_pend = 1;
        hold_val  = bit_out;
      end
      if (bit_valid_7 && bit_ready && cnt7 < 64) begin
        got7[cnt7] = bit_out_7;
        cnt7++;
      end
    end
    @(negedge clk);
    bit_ready = 1'b0;
    chk({name, " ready_after"}, {sym_ready, bit_valid}, 2'b10);
    chk({name, " count"}, cnt, n);
    chk({name, " count7"}, cnt7, n);
    chk({name, " last_pos"}, lastpos, n - 1);
    chk({name, " bits_model"}, got, exp10);
    chk({name, " bits7_model"}, got7, exp7);
    if (check_data) chk({name, " bits_data"}, got, data & mask);
    chk({name, " trunc"}, trunc, exp_trunc);
    $display("frame %s n=%0d term=%0d bits=%h bits7=%h trunc=%0d", name, n, term, got, got7, trunc);
  endtask

  logic [63:0] d;

  initial begin
    // asynchronous reset, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("reset_outs", {sym_ready, bit_valid, bit_out, bit_last, busy, trunc}, 6'b0);
    chk("reset_outs7", {sym_ready_7, bit_valid_7, busy_7, trunc_7}, 4'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_before_edge", sym_ready, 0);
    @(posedge clk);
    #1 chk("ready_after_edge", sym_ready, 1);

    // clean tail-terminated frame
    d = 64'h0B5;
    encode(d, 12);
    run_frame("clean", 12, 1'b1, 1'b1, 1'b0, 1'b1, d, 1'b0);

    // one full-strength inverted code bit
    encode(d, 12);
    s0[5] = SMAX - s0[5];
    run_frame("flip5", 12, 1'b1, 1'b1, 1'b0, 1'b1, d, 1'b0);

    // two erasure-like symbols
    encode(d, 12);
    s0[3] = 3; s1[3] = 3; s0[9] = 3; s1[9] = 3;
    run_frame("erase", 12, 1'b1, 1'b1, 1'b1, 1'b1, d, 1'b0);

    // 64 symbols without sym_last: truncated, best-state start
    d = {$urandom(), $urandom()};
    encode(d, 64);
    run_frame("trunc64", 64, 1'b0, 1'b0, 1'b1, 1'b1, d, 1'b1);

    // sym_last on the 64th symbol: no truncation
    d = {$urandom(), $urandom()};
    encode(d, 64);
    run_frame("last64", 64, 1'b0, 1'b1, 1'b1, 1'b1, d, 1'b0);

    // all-inverted symbols: exercises metric saturation on the narrow instance
    d = {$urandom(), $urandom()};
    encode(d, 64);
    for (int i = 0; i < 64; i++) begin s0[i] = SMAX - s0[i]; s1[i] = SMAX - s1[i]; end
    run_frame("inverted", 64, 1'b0, 1'b1, 1'b0, 1'b0, d, 1'b0);

    // random soft frames
    for (int f = 0; f < 3; f++) begin
      int n;
      bit tm;
      n  = $urandom_range(1, 40);
      tm = bit'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin s0[i] = $urandom_range(0, 7); s1[i] = $urandom_range(0, 7); end
      run_frame("random", n, tm, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
    end

    // reset during the ACS of symbol 4
    d = 64'h0B5;
    encode(d, 12);
    for (int i = 0; i <= 4; i++) begin
      int wd;
      @(negedge clk);
      sym_valid = 1'b1;
      sym_c0 = 3'(s0[i]);
      sym_c1 = 3'(s1[i]);
      term_mode = 1'b1;
      wd = 0;
      while (!sym_ready && wd < 200) begin @(negedge clk); wd++; end
      @(posedge clk);
    end
    #3;
    sym_valid = 1'b0;
    chk("busy_in_acs", {busy, sym_ready}, 2'b10);
    #10 rst = 1'b1;
    #1;
    chk("midreset_outs", {sym_ready, bit_valid, bit_out, bit_last, busy, trunc}, 6'b0);
    chk("midreset_outs7", {sym_ready_7, bit_valid_7, busy_7, trunc_7}, 4'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midreset_ready_low", sym_ready, 0);
    @(posedge clk);
    #1 chk("midreset_ready_high", sym_ready, 1);
    run_frame("after_reset", 12, 1'b1, 1'b1, 1'b0, 1'b1, d, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
